// File: rtl/msrv32_store_pkg.sv
// msrv32_store_pkg: state encodings, store size codes and AHB response codes for the store path
package msrv32_store_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] SZ_SB = 2'b00;
  localparam logic [1:0] SZ_SH = 2'b01;
  localparam logic [1:0] SZ_SW = 2'b10;
  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERROR = 1'b1;
endpackage

// File: rtl/msrv32_store_align.sv
// msrv32_store_align: maps store size and byte offset to lane-replicated data, byte mask and misalign flag
module msrv32_store_align
  import msrv32_store_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  output logic [31:0] data,
  output logic [3:0]  mask,
  output logic        misalign
);
  always_comb begin
    data = size == SZ_SB ? {4{rs2[7:0]}} : size == SZ_SH ? {2{rs2[15:0]}} : rs2;
    mask = size == SZ_SB ? 4'b0001 << offset : size == SZ_SH ? (offset[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    misalign = size == SZ_SB ? 1'b0 : size == SZ_SH ? offset[0] : |offset;
  end
endmodule

// File: rtl/msrv32_store_unit.sv
// msrv32_store_unit: accepts pipeline stores and drives a two-phase AHB-style write with per-phase timeout
module msrv32_store_unit
  import msrv32_store_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        store_req_in,
  input  logic [1:0]  store_size_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic        stall_out,
  output logic        store_done_out,
  output logic        store_err_out
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    mask;
  logic [31:0]   al_data;
  logic [3:0]    al_mask;
  logic          misalign;
  msrv32_store_align u_align (
    .size(store_size_in),
    .offset(iadder_in[1:0]),
    .rs2(rs2_in),
    .data(al_data),
    .mask(al_mask),
    .misalign(misalign)
  );
  assign ms_riscv32_mp_dmwr_mask_out = state == ST_IDLE ? 4'b0000 : mask;
  assign ms_riscv32_mp_dmwr_req_out = state == ST_ADDR;
  assign stall_out = state != ST_IDLE;
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state <= ST_IDLE;
      cnt <= '0;
      mask <= 4'b0000;
      ms_riscv32_mp_dmaddr_out <= 32'h0;
      ms_riscv32_mp_dmdata_out <= 32'h0;
      store_done_out <= 1'b0;
      store_err_out <= 1'b0;
    end else begin
      store_done_out <= 1'b0;
      store_err_out <= 1'b0;
      if (state == ST_IDLE) begin
        if (store_req_in && misalign) store_err_out <= 1'b1;
        else if (store_req_in) begin
          ms_riscv32_mp_dmaddr_out <= {iadder_in[31:2], 2'b00};
          ms_riscv32_mp_dmdata_out <= al_data;
          mask <= al_mask;
          cnt <= '0;
          state <= ST_ADDR;
        end
      end else if (ahb_ready_in) begin
        cnt <= '0;
        state <= state == ST_ADDR ? ST_DATA : ST_IDLE;
        store_done_out <= state == ST_DATA && ahb_resp_in == RESP_OKAY;
        store_err_out <= state == ST_DATA && ahb_resp_in == RESP_ERROR;
      end else if (cnt == LAST) begin
        cnt <= '0;
        state <= ST_IDLE;
        store_err_out <= 1'b1;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_msrv32_store_unit.sv
// tb_msrv32_store_unit: scoreboard-driven self-checking bench for the store unit
module tb_msrv32_store_unit;
  import msrv32_store_pkg::*;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        mis;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        ready = 1'b1;
  logic        resp = 1'b0;
  logic [31:0] dm_addr, dm_data;
  logic [3:0]  dm_mask;
  logic        dm_req, stall, done, err;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  msrv32_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .store_req_in(req),
    .store_size_in(size),
    .iadder_in(addr),
    .rs2_in(rs2),
    .ahb_ready_in(ready),
    .ahb_resp_in(resp),
    .ms_riscv32_mp_dmaddr_out(dm_addr),
    .ms_riscv32_mp_dmdata_out(dm_data),
    .ms_riscv32_mp_dmwr_mask_out(dm_mask),
    .ms_riscv32_mp_dmwr_req_out(dm_req),
    .stall_out(stall),
    .store_done_out(done),
    .store_err_out(err)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a & 32'hFFFF_FFFC;
    e.mask = 4'b0000;
    if (sz == 2'd0) begin
      e.data = {24'h0, d[7:0]} * 32'h0101_0101;
      e.mask[a[1:0]] = 1'b1;
      e.mis = 1'b0;
    end else if (sz == 2'd1) begin
      e.data = {16'h0, d[15:0]} * 32'h0001_0001;
      e.mask = a[1] ? 4'b1100 : 4'b0011;
      e.mis = a[0];
    end else begin
      e.data = d;
      e.mask = 4'b1111;
      e.mis = a[1:0] != 2'b00;
    end
    return e;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1;
    size = sz;
    addr = a;
    rs2 = d;
    sb.push_back(model(sz, a, d));
    tick();
    req = 1'b0;
  endtask
  task automatic wait_pulse(input int budget, output int n, output logic d, output logic e);
    n = 0;
    d = 1'b0;
    e = 1'b0;
    while (n < budget && !d && !e) begin
      tick();
      n++;
      d = done;
      e = err;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if ({dm_addr, dm_data, dm_mask, dm_req, stall, done, err} !== 71'h0) begin errors++; $display("FAIL reset_outputs: got addr=%h data=%h mask=%b req=%b stall=%b done=%b err=%b, want all 0", dm_addr, dm_data, dm_mask, dm_req, stall, done, err); end
    rst = 1'b0;
    tick();
    checks++; if (stall !== 1'b0 || dm_req !== 1'b0) begin errors++; $display("FAIL reset_idle: got stall=%b req=%b want 0 0", stall, dm_req); end
  endtask
  task automatic test_sb();
    exp_t e; int n; logic d, x;
    ready = 1'b1;
    resp = RESP_OKAY;
    drive_store(SZ_SB, 32'h1003, 32'hAABBCCDD);
    e = sb.pop_front();
    checks++; if (dm_addr !== e.addr || dm_data !== e.data || dm_mask !== e.mask) begin errors++; $display("FAIL sb_lanes: got %h/%h/%b want %h/%h/%b", dm_addr, dm_data, dm_mask, e.addr, e.data, e.mask); end
    checks++; if (dm_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL sb_req: got req=%b stall=%b want 1 1", dm_req, stall); end
    tick();
    checks++; if (dm_req !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sb_data_phase: got req=%b stall=%b done=%b want 0 1 0", dm_req, stall, done); end
    wait_pulse(1, n, d, x);
    checks++; if (d !== 1'b1 || x !== 1'b0 || stall !== 1'b0 || dm_mask !== 4'b0000) begin errors++; $display("FAIL sb_done: got done=%b err=%b stall=%b mask=%b want 1 0 0 0000", d, x, stall, dm_mask); end
  endtask
  task automatic test_sh_wait();
    exp_t e; int n; logic d, x;
    ready = 1'b0;
    drive_store(SZ_SH, 32'h2002, 32'h12345678);
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      checks++; if (dm_req !== 1'b1 || stall !== 1'b1 || dm_mask !== e.mask || dm_data !== e.data || dm_addr !== e.addr) begin errors++; $display("FAIL sh_addr_hold[%0d]: got req=%b stall=%b %h/%h/%b want 1 1 %h/%h/%b", i, dm_req, stall, dm_addr, dm_data, dm_mask, e.addr, e.data, e.mask); end
      ready = i == 3;
      tick();
    end
    checks++; if (dm_req !== 1'b0 || stall !== 1'b1 || dm_mask !== e.mask) begin errors++; $display("FAIL sh_data_phase: got req=%b stall=%b mask=%b want 0 1 %b", dm_req, stall, dm_mask, e.mask); end
    wait_pulse(4, n, d, x);
    checks++; if (d !== 1'b1 || x !== 1'b0 || n != 1) begin errors++; $display("FAIL sh_done: got done=%b err=%b after %0d want 1 0 after 1", d, x, n); end
  endtask
  task automatic test_misalign();
    exp_t e;
    logic [1:0] szs[2] = '{SZ_SW, 2'b11};
    logic [31:0] adr[2] = '{32'h3001, 32'h3002};
    ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_store(szs[i], adr[i], 32'hDEADBEEF);
      e = sb.pop_front();
      checks++; if (err !== e.mis || dm_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL misalign[%0d]: got err=%b req=%b stall=%b done=%b want %b 0 0 0", i, err, dm_req, stall, done, e.mis); end
      tick();
      checks++; if (err !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL misalign_pulse[%0d]: got err=%b stall=%b want 0 0", i, err, stall); end
    end
  endtask
  task automatic test_bus_err();
    exp_t e; int n; logic d, x;
    ready = 1'b1;
    resp = RESP_ERROR;
    drive_store(SZ_SW, 32'h4000, 32'h0BADF00D);
    e = sb.pop_front();
    checks++; if (dm_addr !== e.addr || dm_data !== e.data || dm_mask !== e.mask) begin errors++; $display("FAIL buserr_lanes: got %h/%h/%b want %h/%h/%b", dm_addr, dm_data, dm_mask, e.addr, e.data, e.mask); end
    wait_pulse(4, n, d, x);
    checks++; if (x !== 1'b1 || d !== 1'b0 || n != 2 || stall !== 1'b0) begin errors++; $display("FAIL buserr_pulse: got err=%b done=%b n=%0d stall=%b want 1 0 2 0", x, d, n, stall); end
    resp = RESP_OKAY;
  endtask
  task automatic test_back_to_back();
    exp_t e; int n, hi; logic d, x;
    ready = 1'b0;
    drive_store(SZ_SW, 32'h8000, 32'h55AA55AA);
    e = sb.pop_front();
    n = 0;
    hi = 0;
    while (n < 40 && !err) begin
      if (dm_req) hi++;
      tick();
      n++;
    end
    checks++; if (err !== 1'b1 || hi != 16 || dm_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL timeout: got err=%b req_cycles=%0d req=%b done=%b stall=%b want 1 16 0 0 0", err, hi, dm_req, done, stall); end
    ready = 1'b1;
    drive_store(SZ_SB, 32'h5001, 32'h11223344);
    e = sb.pop_front();
    checks++; if (dm_req !== 1'b1 || dm_addr !== e.addr || dm_data !== e.data || dm_mask !== e.mask) begin errors++; $display("FAIL b2b_accept: got req=%b %h/%h/%b want 1 %h/%h/%b", dm_req, dm_addr, dm_data, dm_mask, e.addr, e.data, e.mask); end
    wait_pulse(4, n, d, x);
    checks++; if (d !== 1'b1 || x !== 1'b0 || n != 2) begin errors++; $display("FAIL b2b_done: got done=%b err=%b n=%0d want 1 0 2", d, x, n); end
  endtask
  task automatic test_reset_mid();
    exp_t e; int n; logic d, x;
    ready = 1'b1;
    drive_store(SZ_SW, 32'h6000, 32'hCAFEF00D);
    e = sb.pop_front();
    tick();
    ready = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if ({dm_addr, dm_data, dm_mask, dm_req, stall, done, err} !== 71'h0) begin errors++; $display("FAIL rst_mid: got addr=%h data=%h mask=%b req=%b stall=%b done=%b err=%b want all 0", dm_addr, dm_data, dm_mask, dm_req, stall, done, err); end
    rst = 1'b0;
    ready = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || err !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_mid_nopulse: got done=%b err=%b stall=%b want 0 0 0", done, err, stall); end
    drive_store(SZ_SH, 32'h7000, 32'h0000BEEF);
    e = sb.pop_front();
    checks++; if (dm_addr !== e.addr || dm_data !== e.data || dm_mask !== e.mask) begin errors++; $display("FAIL rst_after_lanes: got %h/%h/%b want %h/%h/%b", dm_addr, dm_data, dm_mask, e.addr, e.data, e.mask); end
    wait_pulse(4, n, d, x);
    checks++; if (d !== 1'b1 || n != 2) begin errors++; $display("FAIL rst_after_done: got done=%b n=%0d want 1 2", d, n); end
  endtask
  task automatic test_random();
    exp_t e; int n; logic d, x, r;
    for (int i = 0; i < 24; i++) begin
      r = 1'($urandom_range(0, 1));
      resp = r;
      ready = 1'($urandom_range(0, 1));
      drive_store(2'($urandom_range(0, 3)), $urandom, $urandom);
      e = sb.pop_front();
      if (e.mis) begin
        checks++; if (err !== 1'b1 || dm_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rand_mis[%0d]: got err=%b req=%b stall=%b want 1 0 0", i, err, dm_req, stall); end
      end else begin
        checks++; if (dm_addr !== e.addr || dm_data !== e.data || dm_mask !== e.mask || dm_req !== 1'b1) begin errors++; $display("FAIL rand_lanes[%0d]: got %h/%h/%b req=%b want %h/%h/%b 1", i, dm_addr, dm_data, dm_mask, dm_req, e.addr, e.data, e.mask); end
        n = 0; d = 1'b0; x = 1'b0;
        while (n < 40 && !d && !x) begin
          ready = $urandom_range(0, 2) != 0;
          tick();
          n++;
          d = done;
          x = err;
        end
        checks++; if (d !== !r || x !== r) begin errors++; $display("FAIL rand_result[%0d]: got done=%b err=%b want %b %b", i, d, x, !r, r); end
      end
      tick();
    end
    resp = RESP_OKAY;
  endtask
  initial begin
    test_reset();
    test_sb();
    test_sh_wait();
    test_misalign();
    test_bus_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
